hazard_redirect_ctrl: RTL and testbench

//  Pipeline control source feeding the fetch stage and the IF/ID, ID/EX registers.

---
 rtl/hazard_redirect_ctrl.sv | 123 ++++++++++++
 tb/tb_hazard_redirect_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_redirect_ctrl.sv
// Pipeline hazard and redirect control: resolves E-stage control transfers into a
// fetch redirect plus flush window, detects E->D load-use hazards for a one-cycle
// stall, and keeps saturating perf counters and a sticky misalign flag.
module hazard_redirect_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_d,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic             use_rs1_d,
    input  logic             use_rs2_d,
    input  logic             valid_e,
    input  logic [4:0]       rd_e,
    input  logic             load_e,
    input  logic             jal_e,
    input  logic             jalr_e,
    input  logic             branch_taken_e,
    input  logic [31:0]      alu_result_e,
    input  logic             cnt_clear,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic             misalign_err,
    output logic [CNT_W-1:0] cnt_redirect,
    output logic [CNT_W-1:0] cnt_stall
);

    typedef enum logic {StRun, StFlush} state_t;

    state_t           r_state;
    logic [2:0]       r_fcnt;
    logic [CNT_W-1:0] r_cnt_redirect;
    logic [CNT_W-1:0] r_cnt_stall;
    logic             r_misalign;

    logic             w_run;
    logic             w_xfer;
    logic             w_take;
    logic             w_lu;
    logic             w_stall;
    logic             w_mis;
    logic [31:0]      w_target;

    // Transfer / hazard decode; FLUSH masks both, and a transfer masks the stall
    always_comb begin
        w_run    = (r_state == StRun);
        w_xfer   = valid_e & (jal_e | jalr_e | branch_taken_e);
        w_take   = w_run & w_xfer;
        w_lu     = valid_e & load_e & (rd_e != 5'd0) & valid_d &
                   ((use_rs1_d & (rs1_d == rd_e)) | (use_rs2_d & (rs2_d == rd_e)));
        w_stall  = w_run & ~w_xfer & w_lu;
        w_target = jalr_e ? {alu_result_e[31:1], 1'b0} : alu_result_e;
        // JALR drops bit 0, so only bit 1 can still misalign its target
        w_mis    = jalr_e ? alu_result_e[1] : (alu_result_e[1:0] != 2'b00);
    end

    // Zero-latency control outputs, forced low while reset is held
    always_comb begin
        redirect_valid = ~rst & w_take;
        redirect_pc    = redirect_valid ? w_target : 32'd0;
        stall_f        = ~rst & w_stall;
        stall_d        = ~rst & w_stall;
        flush_d        = ~rst & (w_take | ~w_run);
        flush_e        = ~rst & (w_take | ~w_run | w_stall);
        misalign_err   = r_misalign;
        cnt_redirect   = r_cnt_redirect;
        cnt_stall      = r_cnt_stall;
    end

    // Flush-window FSM, saturating counters and sticky misalign flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= StRun;
            r_fcnt         <= 3'd0;
            r_cnt_redirect <= '0;
            r_cnt_stall    <= '0;
            r_misalign     <= 1'b0;
        end else begin
            case (r_state)
                StRun: begin
                    if (w_xfer && (FLUSH_CYCLES > 1)) begin
                        r_state <= StFlush;
                        r_fcnt  <= 3'(FLUSH_CYCLES - 1);
                    end
                end
                StFlush: begin
                    if (r_fcnt == 3'd1) begin
                        r_state <= StRun;
                    end
                    r_fcnt <= r_fcnt - 3'd1;
                end
                default: begin
                    r_state <= StRun;
                    r_fcnt  <= 3'd0;
                end
            endcase

            // Clear beats any same-cycle increment or misalign set
            if (cnt_clear) begin
                r_cnt_redirect <= '0;
                r_cnt_stall    <= '0;
                r_misalign     <= 1'b0;
            end else begin
                if (w_take && !(&r_cnt_redirect)) begin
                    r_cnt_redirect <= r_cnt_redirect + CNT_W'(1);
                end
                if (w_stall && !(&r_cnt_stall)) begin
                    r_cnt_stall <= r_cnt_stall + CNT_W'(1);
                end
                if (w_take && w_mis) begin
                    r_misalign <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hazard_redirect_ctrl.sv
// Scoreboard bench: stimulus pushes hand-computed expectations per cycle, a monitor
// pops and compares at the falling edge. Instance A: FLUSH_CYCLES=1, CNT_W=32.
// Instance B: FLUSH_CYCLES=3, CNT_W=4. Both share inputs; each entry names its instance.
module tb_hazard_redirect_ctrl;

    typedef struct packed {
        logic        rst;
        logic        clr;
        logic        vd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic        ve;
        logic [4:0]  rd;
        logic        ld;
        logic        jal;
        logic        jalr;
        logic        bt;
        logic [31:0] alu;
    } stim_t;

    typedef struct packed {
        logic        sel;
        logic        rv;
        logic [31:0] pc;
        logic        sf;
        logic        sd;
        logic        fd;
        logic        fe;
        logic        mis;
        logic [31:0] cr;
        logic [31:0] cs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_d = 1'b0, use_rs1_d = 1'b0, use_rs2_d = 1'b0;
    logic [4:0]  rs1_d = 5'd0, rs2_d = 5'd0, rd_e = 5'd0;
    logic        valid_e = 1'b0, load_e = 1'b0, jal_e = 1'b0, jalr_e = 1'b0;
    logic        branch_taken_e = 1'b0, cnt_clear = 1'b0;
    logic [31:0] alu_result_e = 32'd0;

    logic        a_rv, a_sf, a_sd, a_fd, a_fe, a_mis;
    logic [31:0] a_pc, a_cr, a_cs;
    logic        b_rv, b_sf, b_sd, b_fd, b_fe, b_mis;
    logic [31:0] b_pc;
    logic [3:0]  b_cr, b_cs;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_cyc    = 0;

    always #5 clk = ~clk;

    hazard_redirect_ctrl #(.FLUSH_CYCLES(1), .CNT_W(32)) u_dut_a (
        .clk(clk), .rst(rst), .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
        .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d), .valid_e(valid_e), .rd_e(rd_e),
        .load_e(load_e), .jal_e(jal_e), .jalr_e(jalr_e), .branch_taken_e(branch_taken_e),
        .alu_result_e(alu_result_e), .cnt_clear(cnt_clear),
        .redirect_valid(a_rv), .redirect_pc(a_pc), .stall_f(a_sf), .stall_d(a_sd),
        .flush_d(a_fd), .flush_e(a_fe), .misalign_err(a_mis),
        .cnt_redirect(a_cr), .cnt_stall(a_cs)
    );

    hazard_redirect_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
        .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d), .valid_e(valid_e), .rd_e(rd_e),
        .load_e(load_e), .jal_e(jal_e), .jalr_e(jalr_e), .branch_taken_e(branch_taken_e),
        .alu_result_e(alu_result_e), .cnt_clear(cnt_clear),
        .redirect_valid(b_rv), .redirect_pc(b_pc), .stall_f(b_sf), .stall_d(b_sd),
        .flush_d(b_fd), .flush_e(b_fe), .misalign_err(b_mis),
        .cnt_redirect(b_cr), .cnt_stall(b_cs)
    );

    function automatic stim_t s_idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t s_xfer(logic jal, logic jalr, logic bt, logic [31:0] alu);
        stim_t s;
        s      = '0;
        s.ve   = 1'b1;
        s.jal  = jal;
        s.jalr = jalr;
        s.bt   = bt;
        s.alu  = alu;
        return s;
    endfunction

    function automatic stim_t s_lu(logic [4:0] rd, logic [4:0] rs1, logic u1,
                                   logic [4:0] rs2, logic u2);
        stim_t s;
        s     = '0;
        s.ve  = 1'b1;
        s.ld  = 1'b1;
        s.rd  = rd;
        s.vd  = 1'b1;
        s.rs1 = rs1;
        s.u1  = u1;
        s.rs2 = rs2;
        s.u2  = u2;
        return s;
    endfunction

    function automatic exp_t ex(logic sel, logic rv, logic [31:0] pc, logic sf, logic fd,
                                logic fe, logic mis, int cr, int cs);
        exp_t e;
        e.sel = sel;
        e.rv  = rv;
        e.pc  = pc;
        e.sf  = sf;
        e.sd  = sf;
        e.fd  = fd;
        e.fe  = fe;
        e.mis = mis;
        e.cr  = 32'(cr);
        e.cs  = 32'(cs);
        return e;
    endfunction

    task automatic cyc(input stim_t s, input exp_t e);
        @(posedge clk);
        #1;
        rst            = s.rst;
        cnt_clear      = s.clr;
        valid_d        = s.vd;
        rs1_d          = s.rs1;
        rs2_d          = s.rs2;
        use_rs1_d      = s.u1;
        use_rs2_d      = s.u2;
        valid_e        = s.ve;
        rd_e           = s.rd;
        load_e         = s.ld;
        jal_e          = s.jal;
        jalr_e         = s.jalr;
        branch_taken_e = s.bt;
        alu_result_e   = s.alu;
        q.push_back(e);
    endtask

    // Monitor: compare the named instance's outputs against the queued expectation
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            exp_t a;
            e = q.pop_front();
            n_cyc++;
            if (e.sel == 1'b0) begin
                a = {1'b0, a_rv, a_pc, a_sf, a_sd, a_fd, a_fe, a_mis, a_cr, a_cs};
            end else begin
                a = {1'b1, b_rv, b_pc, b_sf, b_sd, b_fd, b_fe, b_mis,
                     {28'd0, b_cr}, {28'd0, b_cs}};
            end
            n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL chk%0d dut%s: got rv=%b pc=%h sf=%b sd=%b fd=%b fe=%b mis=%b cr=%0d cs=%0d; want rv=%b pc=%h sf=%b sd=%b fd=%b fe=%b mis=%b cr=%0d cs=%0d",
                         n_cyc, e.sel ? "B" : "A",
                         a.rv, a.pc, a.sf, a.sd, a.fd, a.fe, a.mis, a.cr, a.cs,
                         e.rv, e.pc, e.sf, e.sd, e.fd, e.fe, e.mis, e.cr, e.cs);
            end
        end
    end

    initial begin
        stim_t s;

        // ---------------- Instance A: FLUSH_CYCLES=1, CNT_W=32 ----------------
        s = s_xfer(1, 0, 0, 32'h100); s.rst = 1'b1;
        cyc(s, ex(0, 0, 0, 0, 0, 0, 0, 0, 0));                       // outputs 0 under reset
        cyc(s_idle(), ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc(s_lu(5, 5, 1, 0, 0), ex(0, 0, 0, 1, 0, 1, 0, 0, 0));     // load-use on rs1
        cyc(s_idle(), ex(0, 0, 0, 0, 0, 0, 0, 0, 1));
        cyc(s_lu(0, 0, 1, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 0, 1));     // rd=0: no hazard
        cyc(s_lu(7, 5, 0, 7, 1), ex(0, 0, 0, 1, 0, 1, 0, 0, 1));     // load-use on rs2
        cyc(s_lu(7, 7, 0, 7, 0), ex(0, 0, 0, 0, 0, 0, 0, 0, 2));     // match but unused
        cyc(s_xfer(1, 0, 0, 32'h100), ex(0, 1, 32'h100, 0, 1, 1, 0, 0, 2));
        cyc(s_idle(), ex(0, 0, 0, 0, 0, 0, 0, 1, 2));                // one-cycle flush
        cyc(s_xfer(0, 1, 0, 32'h203), ex(0, 1, 32'h202, 0, 1, 1, 0, 1, 2));
        cyc(s_idle(), ex(0, 0, 0, 0, 0, 0, 1, 2, 2));                // misalign sticky
        s = s_idle(); s.clr = 1'b1;
        cyc(s, ex(0, 0, 0, 0, 0, 0, 1, 2, 2));
        cyc(s_idle(), ex(0, 0, 0, 0, 0, 0, 0, 0, 0));                // cleared
        cyc(s_xfer(0, 0, 1, 32'h102), ex(0, 1, 32'h102, 0, 1, 1, 0, 0, 0));
        s = s_xfer(0, 1, 0, 32'h201); s.clr = 1'b1;
        cyc(s, ex(0, 1, 32'h200, 0, 1, 1, 1, 1, 0));                 // clear + xfer
        cyc(s_idle(), ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
        s = s_lu(5, 5, 1, 0, 0); s.jal = 1'b1; s.alu = 32'h40;
        cyc(s, ex(0, 1, 32'h40, 0, 1, 1, 0, 0, 0));                  // xfer beats load-use
        cyc(s_idle(), ex(0, 0, 0, 0, 0, 0, 0, 1, 0));
        s = s_xfer(1, 0, 0, 32'h80); s.ve = 1'b0;
        cyc(s, ex(0, 0, 0, 0, 0, 0, 0, 1, 0));                       // invalid E: no xfer
        s = s_lu(5, 5, 1, 0, 0); s.vd = 1'b0;
        cyc(s, ex(0, 0, 0, 0, 0, 0, 0, 1, 0));                       // invalid D: no stall
        cyc(s_xfer(1, 0, 0, 32'h10), ex(0, 1, 32'h10, 0, 1, 1, 0, 1, 0));
        cyc(s_xfer(1, 0, 0, 32'h20), ex(0, 1, 32'h20, 0, 1, 1, 0, 2, 0));
        cyc(s_idle(), ex(0, 0, 0, 0, 0, 0, 0, 3, 0));

        // ---------------- Instance B: FLUSH_CYCLES=3, CNT_W=4 ----------------
        s = s_xfer(0, 0, 1, 32'h300); s.rst = 1'b1;
        cyc(s, ex(1, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc(s_idle(), ex(1, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc(s_xfer(0, 0, 1, 32'h300), ex(1, 1, 32'h300, 0, 1, 1, 0, 0, 0));
        cyc(s_xfer(1, 0, 0, 32'h400), ex(1, 0, 0, 0, 1, 1, 0, 1, 0)); // ignored in FLUSH
        cyc(s_lu(5, 5, 1, 0, 0), ex(1, 0, 0, 0, 1, 1, 0, 1, 0));      // ignored in FLUSH
        cyc(s_idle(), ex(1, 0, 0, 0, 0, 0, 0, 1, 0));
        cyc(s_xfer(0, 0, 1, 32'h500), ex(1, 1, 32'h500, 0, 1, 1, 0, 1, 0));
        cyc(s_idle(), ex(1, 0, 0, 0, 1, 1, 0, 2, 0));
        s = s_idle(); s.rst = 1'b1;
        cyc(s, ex(1, 0, 0, 0, 0, 0, 0, 0, 0));                        // reset mid-FLUSH
        cyc(s_idle(), ex(1, 0, 0, 0, 0, 0, 0, 0, 0));                 // back in RUN
        for (int i = 0; i < 20; i++) begin
            int c0;
            int c1;
            c0 = (i > 15) ? 15 : i;
            c1 = (i + 1 > 15) ? 15 : i + 1;
            cyc(s_xfer(1, 0, 0, 32'h1000 + 32'(i * 4)),
                ex(1, 1, 32'h1000 + 32'(i * 4), 0, 1, 1, 0, c0, 0));
            cyc(s_idle(), ex(1, 0, 0, 0, 1, 1, 0, c1, 0));
            cyc(s_idle(), ex(1, 0, 0, 0, 1, 1, 0, c1, 0));
        end
        s = s_xfer(1, 0, 0, 32'h44); s.clr = 1'b1;
        cyc(s, ex(1, 1, 32'h44, 0, 1, 1, 0, 15, 0));                  // clear beats increment
        cyc(s_idle(), ex(1, 0, 0, 0, 1, 1, 0, 0, 0));
        cyc(s_idle(), ex(1, 0, 0, 0, 1, 1, 0, 0, 0));
        cyc(s_lu(3, 3, 1, 0, 0), ex(1, 0, 0, 1, 0, 1, 0, 0, 0));
        cyc(s_idle(), ex(1, 0, 0, 0, 0, 0, 0, 0, 1));

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: got %0d pending entries, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
